// File: rtl/state_timer_if.sv
// state_timer_if
//   Bundles the controller-facing signals of state_timer.
//   master : the controller FSM side (drives state, pause, table writes).
//   slave  : the timer itself (returns loaded duration, countdown, status).
//   Signals:
//     present_state [STATE_W] current controller FSM state
//     pause                   freezes the countdown while high
//     cfg_we / cfg_addr / cfg_data  duration table write port (ms)
//     t [T_W]                 duration loaded for the current state
//     remaining [T_W]         whole ms left in the current countdown
//     busy                    countdown active
//     timeout                 one-cycle pulse on expiry
`timescale 1ns/1ps
interface state_timer_if #(
  parameter int STATE_W = 4,
  parameter int T_W     = 19
);
  logic [STATE_W-1:0] present_state;
  logic               pause;
  logic               cfg_we;
  logic [STATE_W-1:0] cfg_addr;
  logic [T_W-1:0]     cfg_data;
  logic [T_W-1:0]     t;
  logic [T_W-1:0]     remaining;
  logic               busy;
  logic               timeout;

  modport master (
    output present_state, pause, cfg_we, cfg_addr, cfg_data,
    input  t, remaining, busy, timeout
  );

  modport slave (
    input  present_state, pause, cfg_we, cfg_addr, cfg_data,
    output t, remaining, busy, timeout
  );
endinterface

// File: rtl/state_timer.sv
// state_timer
//   Per-state countdown timer for the train controller. A runtime-writable
//   table holds one duration (ms) per FSM state. Whenever present_state
//   changes, that state's duration is loaded and counted down in ms ticks of
//   TICK_DIV clk cycles; reaching zero raises a one-cycle timeout. A zero
//   duration marks the state as untimed.
//   Ports:
//     clk   system clock, rising edge
//     rst_n asynchronous active-low reset
//     bus   state_timer_if.slave (state, pause, table write, t/remaining/busy/timeout)
`timescale 1ns/1ps
module state_timer #(
  parameter int STATE_W  = 4,
  parameter int T_W      = 19,
  parameter int TICK_DIV = 50000,
  parameter int D3       = 2000,
  parameter int D4       = 1000,
  parameter int D5       = 2000
) (
  input  logic          clk,
  input  logic          rst_n,
  state_timer_if.slave  bus
);

  localparam int N_ENT = 2 ** STATE_W;
  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_COUNT} state_e;

  logic [T_W-1:0]     tbl [N_ENT];
  logic [STATE_W-1:0] prev_q;
  state_e             state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [T_W-1:0]     rem_q, rem_d;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic               timeout_q, timeout_d;

  logic               load;
  logic [T_W-1:0]     load_val;

  assign load     = (bus.present_state != prev_q);
  // The table is read from its registered contents, so a write on the same
  // edge as a load is only seen by later loads (read-before-write).
  assign load_val = tbl[bus.present_state];

  // Duration table.
  // NOTE: this table is reset because the reset contents (D3/D4/D5 defaults)
  // are functional; a plain storage array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        if (i == 3)      tbl[i] <= T_W'(D3);
        else if (i == 4) tbl[i] <= T_W'(D4);
        else if (i == 5) tbl[i] <= T_W'(D5);
        else             tbl[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // State and datapath registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      state_q   <= ST_IDLE;
      t_q       <= '0;
      rem_q     <= '0;
      ps_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      prev_q    <= bus.present_state;
      state_q   <= state_d;
      t_q       <= t_d;
      rem_q     <= rem_d;
      ps_q      <= ps_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. A load always wins over the countdown, which both
  // aborts a running count and suppresses a coincident expiry pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    t_d       = t_q;
    rem_d     = rem_q;
    ps_d      = ps_q;
    timeout_d = 1'b0;

    if (load) begin
      t_d     = load_val;
      rem_d   = load_val;
      ps_d    = '0;
      state_d = (load_val != '0) ? ST_COUNT : ST_IDLE;
    end else if (state_q == ST_COUNT && !bus.pause) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (rem_q != '0) rem_d = rem_q - T_W'(1);
        if (rem_q == T_W'(1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  assign bus.t         = t_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = (state_q == ST_COUNT);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_state_timer.sv
// tb_state_timer
//   Self-checking bench for state_timer with TICK_DIV=4. A reference model
//   tracks the clock cycles left until expiry and derives the expected
//   outputs from that count; directed scenarios pin literal values, then a
//   randomized phase exercises state changes, pauses and table writes.
`timescale 1ns/1ps
module tb_state_timer;

  localparam int STATE_W  = 4;
  localparam int T_W      = 19;
  localparam int TICK_DIV = 4;

  logic clk;
  logic rst_n;

  state_timer_if #(.STATE_W(STATE_W), .T_W(T_W)) bus ();

  state_timer #(
    .STATE_W (STATE_W),
    .T_W     (T_W),
    .TICK_DIV(TICK_DIV),
    .D3      (2000),
    .D4      (1000),
    .D5      (2000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left until expiry, in clk cycles.
  int m_tbl [16];
  int m_prev;
  int m_t;
  int m_left;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_tbl[i] <= 0;
      m_tbl[3] <= 2000;
      m_tbl[4] <= 1000;
      m_tbl[5] <= 2000;
      m_prev   <= 0;
      m_t      <= 0;
      m_left   <= 0;
      m_to     <= 1'b0;
    end else begin
      m_prev <= int'(bus.present_state);
      m_to   <= 1'b0;
      if (int'(bus.present_state) != m_prev) begin
        m_t    <= m_tbl[bus.present_state];
        m_left <= m_tbl[bus.present_state] * TICK_DIV;
      end else if (m_left != 0 && !bus.pause) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_to <= 1'b1;
      end
      if (bus.cfg_we) m_tbl[bus.cfg_addr] <= int'(bus.cfg_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("t",         64'(bus.t),         64'(m_t));
      check("remaining", 64'(bus.remaining), 64'((m_left + TICK_DIV - 1) / TICK_DIV));
      check("busy",      64'(bus.busy),      64'(m_left != 0));
      check("timeout",   64'(bus.timeout),   64'(m_to));
    end
  end

  // Drive a new state; returns at the negedge right after the load edge.
  task automatic load_state(input int s);
    @(negedge clk);
    bus.present_state = STATE_W'(s);
    @(negedge clk);
  endtask

  // Waits for timeout; 'at' is edges since the load edge, -1 if none by limit.
  task automatic wait_timeout(input int start, input int limit, output int at);
    int j;
    j  = start;
    at = -1;
    while (j < limit) begin
      @(negedge clk);
      j++;
      if (bus.timeout === 1'b1) begin
        at = j;
        break;
      end
    end
  endtask

  int at;
  logic [T_W-1:0] held;

  initial begin
    rst_n             = 1'b0;
    bus.present_state = '0;
    bus.pause         = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_data      = '0;
    #1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_t",       64'(bus.t), 0);
    check("rst_rem",     64'(bus.remaining), 0);
    check("rst_busy",    64'(bus.busy), 0);
    check("rst_timeout", 64'(bus.timeout), 0);
    rst_n = 1'b1;

    // 1: reset default duration for state 3.
    load_state(3);
    check("s1_t",    64'(bus.t), 2000);
    check("s1_busy", 64'(bus.busy), 1);
    wait_timeout(0, 9000, at);
    check("s1_timeout_at", 64'(at), 8000);

    // 2: untimed state.
    load_state(7);
    check("s2_t",    64'(bus.t), 0);
    check("s2_busy", 64'(bus.busy), 0);
    wait_timeout(0, 10000, at);
    check("s2_no_timeout", 64'(at), 64'(-1));

    // 3: abort a running count by changing state.
    load_state(4);
    repeat (1999) @(negedge clk);
    bus.present_state = 4'd5;
    @(negedge clk);
    check("s3_rem",     64'(bus.remaining), 2000);
    check("s3_timeout", 64'(bus.timeout), 0);
    wait_timeout(0, 9000, at);
    check("s3_timeout_at", 64'(at), 8000);

    // 4: pause for 100 cycles mid-count.
    load_state(4);
    repeat (1000) @(negedge clk);
    check("s4_rem_before", 64'(bus.remaining), 750);
    held = bus.remaining;
    bus.pause = 1'b1;
    repeat (100) @(negedge clk);
    check("s4_rem_paused", 64'(bus.remaining), 64'(held));
    check("s4_busy_paused", 64'(bus.busy), 1);
    bus.pause = 1'b0;
    wait_timeout(1100, 5000, at);
    check("s4_timeout_at", 64'(at), 4100);

    // 5: reprogram entry 9, then overwrite it on the load edge.
    load_state(0);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd9;
    bus.cfg_data = 19'd3;
    @(negedge clk);
    bus.cfg_data      = 19'd5;
    bus.present_state = 4'd9;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("s5_t",   64'(bus.t), 3);
    check("s5_rem", 64'(bus.remaining), 3);
    wait_timeout(0, 100, at);
    check("s5_timeout_at", 64'(at), 12);
    load_state(0);
    load_state(9);
    check("s5_t_new", 64'(bus.t), 5);

    // 6: asynchronous reset mid-count.
    load_state(3);
    repeat (100) @(negedge clk);
    check("s6_busy_before", 64'(bus.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("s6_t",       64'(bus.t), 0);
    check("s6_rem",     64'(bus.remaining), 0);
    check("s6_busy",    64'(bus.busy), 0);
    check("s6_timeout", 64'(bus.timeout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_reload_t",    64'(bus.t), 2000);
    check("s6_reload_busy", 64'(bus.busy), 1);

    // Randomized phase: short durations so expiries happen often.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = STATE_W'(i);
      bus.cfg_data = T_W'($urandom_range(0, 6));
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) bus.present_state = STATE_W'($urandom_range(0, 15));
      bus.pause    = ($urandom_range(0, 9) == 0);
      bus.cfg_we   = ($urandom_range(0, 19) == 0);
      bus.cfg_addr = STATE_W'($urandom_range(0, 15));
      bus.cfg_data = T_W'($urandom_range(0, 6));
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.pause  = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
